vote_encrypt_scheduler: RTL
===========================

// Module: vote_encrypt_scheduler
// PURPOSE
//  Sequences one ballot at a time into the encryption engine. Buffers one decoded vote from
//  vote_processor and assembles a wide nonce from successive 32-bit rand_gen words. When both
//  are ready, it pulses the encryptor start, waits for done with a timeout, and keeps counters.
//  Sits between vote_processor/rand_gen and the encryptor in top_level.
// PARAMETERS
//  RAND_WORD    32         width of one rand_gen output word
//  RAND_WORDS   4          words per nonce; nonce width NW = RAND_WORD*RAND_WORDS
//  ENC_TIMEOUT  1_000_000  max cycles in WAIT before abort (>=2)
// PORTS
//  clk_in            in   1          system clock
//  rst_in            in   1          asynchronous reset, ACTIVE-LOW
//  vote_in           in   1          candidate choice from vote_processor
//  vote_valid_in     in   1          1-cycle strobe qualifying vote_in
//  rand_in           in   RAND_WORD  word from rand_gen
//  rand_valid_in     in   1          qualifies rand_in
//  enc_done_in       in   1          1-cycle strobe: encryptor finished current ballot
//  enc_start_out     out  1          1-cycle strobe launching encryption
//  enc_vote_out      out  1          vote presented to encryptor, stable START..WAIT
//  enc_nonce_out     out  NW         nonce presented to encryptor, stable START..WAIT
//  busy_out          out  1          high in START or WAIT
//  timeout_out       out  1          1-cycle strobe on WAIT timeout
//  launched_cnt_out  out  16         ballots completed with enc_done_in, saturates at 16'hFFFF
//  dropped_cnt_out   out  8          votes lost because buffer was full, saturates at 8'hFF
// BEHAVIOUR
//  Reset (rst_in=0, async): state=FILL, word count=0, nonce=0, vote buffer empty,
//    all outputs 0 including both counters.
//  Vote buffer (1 entry):
//    - vote_valid_in with buffer empty: latch vote_in, buffer full on the next edge.
//    - vote_valid_in with buffer full: vote discarded, dropped_cnt_out+1 (saturating).
//    - The buffer frees on the edge entering START. A vote arriving that same cycle is accepted.
//  State machine (states in package):
//    FILL  - on each rand_valid_in: nonce <= {nonce[NW-RAND_WORD-1:0], rand_in}, cnt+1.
//            When the RAND_WORDS-th word is taken: if the resulting nonce == 0, clear cnt and
//            stay in FILL (zero nonce forbidden); else go to READY.
//    READY - ignores rand_valid_in. If buffer full (registered flag), go to START next edge.
//    START - enc_start_out=1 for exactly this cycle. enc_vote_out/enc_nonce_out registered
//            on entry. Go to WAIT.
//    WAIT  - timer counts from 0 each cycle.
//            enc_done_in: launched_cnt_out+1 (saturating), nonce<=0, cnt<=0, go to FILL.
//            timer==ENC_TIMEOUT-1 without done: timeout_out=1 for one cycle, go to FILL
//            with nonce cleared; that ballot is lost and not counted.
//            enc_done_in in the same cycle as timeout: done wins, no timeout_out.
//  enc_done_in outside WAIT is ignored. rand_valid_in outside FILL is ignored
//    (words are never reused).
//  Latency: nonce READY and vote strobed at edge k -> buffer full after k ->
//    READY->START at k+1 -> enc_start_out high in cycle k+1..k+2.
//  enc_vote_out/enc_nonce_out hold their last values after WAIT until the next START.
//  Mid-operation reset: immediate return to reset values. The encryptor is expected to be
//    reset by the same rst_in.
//  Timer width: $clog2(ENC_TIMEOUT). Counters use no wrap.
// STRUCTURE
//  election_pkg: typedef enum logic [1:0] {FILL, READY, START, WAIT} sched_state_t;
//    localparam RAND_WORD_DEFAULT=32.
//  Sub-module nonce_collector: shift register + word counter + zero check.
//    Ports: clk_in, rst_in, clear_in, en_in, word_in, word_valid_in -> nonce_out, full_out.
//  Parent holds the FSM, vote buffer, WAIT timer and counters.
// TESTING
//  1 Reset: rst_in=0 mid-WAIT -> all outputs 0, state FILL, counters 0, asynchronously.
//  2 Nominal (RAND_WORDS=4): words 1,2,3,4 then vote_in=1 strobe ->
//    enc_nonce_out=128'h1_00000002_00000003_00000004, enc_vote_out=1, one-cycle start 1 cycle
//    after buffer full. enc_done_in -> launched_cnt_out=1.
//  3 Zero nonce: four words of 0 -> no READY, no start. Next words 5,6,7,8 -> start with that nonce.
//  4 Buffer overflow: vote strobes 0 then 1 while in FILL -> dropped_cnt_out=1,
//    launched vote=0. A vote strobed the cycle START is entered -> kept for the next ballot.
//  5 Timeout (ENC_TIMEOUT=16): no enc_done_in -> timeout_out pulse 16 cycles after WAIT entry,
//    launched_cnt_out unchanged. Repeat with done on cycle 16 -> counted, no timeout_out.
//  6 Saturation: 300 dropped votes -> dropped_cnt_out stays 8'hFF.

Source files
------------

// File: rtl/vote_encrypt_scheduler_pkg.sv
// Shared types and defaults for the ballot encryption scheduler.
//   sched_state_t      : scheduler FSM states
//   RAND_WORD_DEFAULT  : default width of one rand_gen word
//   RAND_WORDS_DEFAULT : default number of words per nonce
package vote_encrypt_scheduler_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } sched_state_t;

  localparam int unsigned RAND_WORD_DEFAULT  = 32;
  localparam int unsigned RAND_WORDS_DEFAULT = 4;

endpackage

// File: rtl/vote_encrypt_scheduler_if.sv
// Scheduler <-> encryptor handshake.
//   enc_start_out : 1-cycle launch strobe (scheduler -> encryptor)
//   enc_vote_out  : vote to encrypt, stable from START through WAIT
//   enc_nonce_out : NW-bit nonce, stable from START through WAIT
//   enc_done_in   : 1-cycle completion strobe (encryptor -> scheduler)
interface vote_encrypt_scheduler_if #(
  parameter int unsigned NW = 128
) ();

  logic          enc_start_out;
  logic          enc_vote_out;
  logic [NW-1:0] enc_nonce_out;
  logic          enc_done_in;

  modport master (
    output enc_start_out,
    output enc_vote_out,
    output enc_nonce_out,
    input  enc_done_in
  );

  modport slave (
    input  enc_start_out,
    input  enc_vote_out,
    input  enc_nonce_out,
    output enc_done_in
  );

endinterface

// File: rtl/vote_encrypt_scheduler_nonce_collector.sv
// Assembles a nonce from successive rand_gen words (newest word in the LSBs).
//   clk_in, rst_in : clock, async active-low reset
//   clear_in       : drop the collected nonce and word count
//   en_in          : words are only taken while enabled
//   word_in        : rand_gen word, qualified by word_valid_in
//   nonce_out      : collected nonce (registered)
//   full_out       : strobe, high in the cycle the last word is taken and the
//                    resulting nonce is non-zero
module vote_encrypt_scheduler_nonce_collector #(
  parameter int unsigned RAND_WORD  = 32,
  parameter int unsigned RAND_WORDS = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            clear_in,
  input  logic                            en_in,
  input  logic [RAND_WORD-1:0]            word_in,
  input  logic                            word_valid_in,
  output logic [RAND_WORD*RAND_WORDS-1:0] nonce_out,
  output logic                            full_out
);

  localparam int unsigned NW = RAND_WORD * RAND_WORDS;
  localparam int unsigned CW = (RAND_WORDS > 1) ? $clog2(RAND_WORDS) : 1;

  logic [NW-1:0] nonce_q;
  logic [NW-1:0] shifted;
  logic [CW-1:0] cnt_q;
  logic          take;
  logic          last;

  if (RAND_WORDS > 1) begin : g_shift
    assign shifted = {nonce_q[NW-RAND_WORD-1:0], word_in};
  end else begin : g_single
    assign shifted = word_in;
  end

  assign take      = en_in & word_valid_in;
  assign last      = take && (cnt_q == CW'(RAND_WORDS - 1));
  // A complete all-zero nonce is forbidden: no strobe, collection restarts.
  assign full_out  = last && (shifted != '0);
  assign nonce_out = nonce_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      nonce_q <= '0;
      cnt_q   <= '0;
    end else if (clear_in) begin
      nonce_q <= '0;
      cnt_q   <= '0;
    end else if (take) begin
      nonce_q <= shifted;
      cnt_q   <= last ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/vote_encrypt_scheduler.sv
// Sequences one ballot at a time into the encryptor: buffers one vote, collects a
// nonce, launches encryption and waits for done with a timeout.
//   clk_in, rst_in   : clock, async active-low reset
//   vote_in          : candidate choice, qualified by vote_valid_in
//   rand_in          : rand_gen word, qualified by rand_valid_in
//   enc              : encryptor handshake (start/vote/nonce out, done in)
//   busy_out         : high in START or WAIT
//   timeout_out      : 1-cycle strobe when WAIT times out
//   launched_cnt_out : ballots completed with done (saturating)
//   dropped_cnt_out  : votes lost to a full buffer (saturating)
module vote_encrypt_scheduler
  import vote_encrypt_scheduler_pkg::*;
#(
  parameter int unsigned RAND_WORD   = RAND_WORD_DEFAULT,
  parameter int unsigned RAND_WORDS  = RAND_WORDS_DEFAULT,
  parameter int unsigned ENC_TIMEOUT = 1_000_000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      vote_in,
  input  logic                      vote_valid_in,
  input  logic [RAND_WORD-1:0]      rand_in,
  input  logic                      rand_valid_in,
  vote_encrypt_scheduler_if.master  enc,
  output logic                      busy_out,
  output logic                      timeout_out,
  output logic [15:0]               launched_cnt_out,
  output logic [7:0]                dropped_cnt_out
);

  localparam int unsigned NW = RAND_WORD * RAND_WORDS;
  localparam int unsigned TW = $clog2(ENC_TIMEOUT);

  sched_state_t  state_q;
  logic [TW-1:0] timer_q;
  logic          vbuf_full_q;
  logic          vbuf_vote_q;
  logic [NW-1:0] nonce;
  logic          nonce_full;
  logic          launch;
  logic          done;
  logic          expire;
  logic          clear;

  assign launch = (state_q == READY) && vbuf_full_q;
  assign done   = (state_q == WAIT) && enc.enc_done_in;
  // Done in the same cycle as the last timer value wins over the timeout.
  assign expire = (state_q == WAIT) && !enc.enc_done_in && (timer_q == TW'(ENC_TIMEOUT - 1));
  assign clear  = done | expire;

  vote_encrypt_scheduler_nonce_collector #(
    .RAND_WORD  (RAND_WORD),
    .RAND_WORDS (RAND_WORDS)
  ) u_collector (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .clear_in      (clear),
    .en_in         (state_q == FILL),
    .word_in       (rand_in),
    .word_valid_in (rand_valid_in),
    .nonce_out     (nonce),
    .full_out      (nonce_full)
  );

  // Single-entry vote buffer; the launch edge frees the slot, so a vote arriving
  // on that same edge is accepted for the next ballot.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vbuf_full_q     <= 1'b0;
      vbuf_vote_q     <= 1'b0;
      dropped_cnt_out <= '0;
    end else begin
      if (vote_valid_in && (!vbuf_full_q || launch)) begin
        vbuf_full_q <= 1'b1;
        vbuf_vote_q <= vote_in;
      end else if (launch) begin
        vbuf_full_q <= 1'b0;
      end
      if (vote_valid_in && vbuf_full_q && !launch && (dropped_cnt_out != 8'hFF)) begin
        dropped_cnt_out <= dropped_cnt_out + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q           <= FILL;
      timer_q           <= '0;
      enc.enc_start_out <= 1'b0;
      enc.enc_vote_out  <= 1'b0;
      enc.enc_nonce_out <= '0;
      busy_out          <= 1'b0;
      timeout_out       <= 1'b0;
      launched_cnt_out  <= '0;
    end else begin
      enc.enc_start_out <= 1'b0;
      timeout_out       <= 1'b0;
      unique case (state_q)
        FILL: begin
          if (nonce_full) state_q <= READY;
        end
        READY: begin
          if (launch) begin
            state_q           <= START;
            enc.enc_start_out <= 1'b1;
            enc.enc_vote_out  <= vbuf_vote_q;
            enc.enc_nonce_out <= nonce;
            busy_out          <= 1'b1;
          end
        end
        START: begin
          state_q <= WAIT;
          timer_q <= '0;
        end
        WAIT: begin
          if (done) begin
            state_q  <= FILL;
            busy_out <= 1'b0;
            if (launched_cnt_out != 16'hFFFF) launched_cnt_out <= launched_cnt_out + 16'd1;
          end else if (expire) begin
            state_q     <= FILL;
            busy_out    <= 1'b0;
            timeout_out <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule
